// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//
// Conditions the board slide switches before they reach the switch-to-LED
// logic. Each channel is synchronised into the clk_100mhz domain, then
// filtered so that a new level is only accepted once it has been stable for
// DEBOUNCE_CYCLES consecutive clock edges. Accepted changes are reported
// with single-cycle rise/fall strobes.
//
// Parameters
//   WIDTH            number of independent switch channels
//   SYNC_STAGES      synchroniser flops per channel (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable edges needed to accept a change (>= 2)
//
// Ports
//   clk_100mhz  in   1      system clock
//   rst_n       in   1      asynchronous active-low reset
//   sw_raw      in   WIDTH  raw, asynchronous, bouncing switch levels
//   sw_db       out  WIDTH  debounced level per channel
//   sw_rise     out  WIDTH  one-cycle strobe when sw_db[i] goes 0->1
//   sw_fall     out  WIDTH  one-cycle strobe when sw_db[i] goes 1->0
//   any_change  out  1      OR of all strobes, same cycle as the strobes
// ---------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH           = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Counter advance that holds at the acceptance value, so the counter can
  // never wrap even if the acceptance branch were bypassed.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_LAST) ? CNT_LAST : c + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0]            sync_p [SYNC_STAGES];
  logic [WIDTH-1:0]            sync_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_p1;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0]            db_nxt;
  logic [WIDTH-1:0]            rise_nxt;
  logic [WIDTH-1:0]            fall_nxt;

  // Stage 0: synchroniser chain; the only logic that samples sw_raw.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
    end else begin
      sync_p[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  assign sync_q = sync_p[SYNC_STAGES-1];

  // Stage 1: per-channel stability counters and acceptance decision.
  always_comb begin
    cnt_nxt  = '0;
    db_nxt   = sw_db;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_q[i] == sw_db[i]) begin
        // Input agrees with the accepted level: any partial run was a glitch.
        cnt_nxt[i] = '0;
      end else if (cnt_p1[i] == CNT_LAST) begin
        db_nxt[i]   = sync_q[i];
        cnt_nxt[i]  = '0;
        rise_nxt[i] = sync_q[i];
        fall_nxt[i] = ~sync_q[i];
      end else begin
        cnt_nxt[i] = cnt_sat_inc(cnt_p1[i]);
      end
    end
  end

  // Stage 2: registered level, strobes and the combined change flag.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1     <= '0;
      sw_db      <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      any_change <= 1'b0;
    end else begin
      cnt_p1     <= cnt_nxt;
      sw_db      <= db_nxt;
      sw_rise    <= rise_nxt;
      sw_fall    <= fall_nxt;
      any_change <= |(rise_nxt | fall_nxt);
    end
  end

endmodule
